// File: rtl/poly_coef_extractor.sv
// poly_coef_extractor
// Drives an external black-box evaluator F(x,y,z) through seven fixed sample
// points and recovers the seven signed coefficients of
//   F = a x^2 + b x + c y^2 + d y + e z^2 + f z + g
// from the returned values.
//
// Ports
//   clk              : single clock, rising edge
//   rst              : asynchronous active-low reset
//   start            : one-cycle run request (ignored while busy)
//   ev_rst           : active-low restart to the evaluator (low one cycle per step)
//   ev_en            : evaluator enable (high while launching / waiting)
//   ev_in0..ev_in2   : x, y, z sample point (unsigned 4-bit)
//   ev_out           : signed 19-bit evaluator result
//   ev_done          : evaluator result-ready flag (accepted on its rising edge)
//   a..g             : recovered coefficients (signed 5-bit)
//   busy/valid/err/timeout : run status
module poly_coef_extractor #(
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               ev_rst,
  output logic               ev_en,
  output logic [3:0]         ev_in0,
  output logic [3:0]         ev_in1,
  output logic [3:0]         ev_in2,
  input  logic signed [18:0] ev_out,
  input  logic               ev_done,
  output logic signed [4:0]  a,
  output logic signed [4:0]  b,
  output logic signed [4:0]  c,
  output logic signed [4:0]  d,
  output logic signed [4:0]  e,
  output logic signed [4:0]  f,
  output logic signed [4:0]  g,
  output logic               busy,
  output logic               valid,
  output logic               err,
  output logic               timeout
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LAUNCH  = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] COMPUTE = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam logic [2:0] LAST_STEP = 3'd6;

  // Wait counter holds 0..TIMEOUT-1; the last value marks the final allowed cycle.
  localparam int              CW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0]   CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]   WAIT_LAST = CW'(TIMEOUT - 1);

  // Sample point for each step, packed as {x, y, z}.
  function automatic logic [11:0] step_inputs(input logic [2:0] step);
    logic [11:0] pt;
    case (step)
      3'd0:    pt = {4'd0, 4'd0, 4'd0};
      3'd1:    pt = {4'd2, 4'd0, 4'd0};
      3'd2:    pt = {4'd1, 4'd0, 4'd0};
      3'd3:    pt = {4'd0, 4'd2, 4'd0};
      3'd4:    pt = {4'd0, 4'd1, 4'd0};
      3'd5:    pt = {4'd0, 4'd0, 4'd2};
      3'd6:    pt = {4'd0, 4'd0, 4'd1};
      default: pt = 12'h000;
    endcase
    return pt;
  endfunction

  // True when a 19-bit value fits the signed 5-bit range [-16, 15].
  function automatic logic in_range(input logic signed [18:0] v);
    return (v[18:4] == 15'h0000) || (v[18:4] == 15'h7fff);
  endfunction

  logic [2:0]         state_r, state_s;
  logic [2:0]         step_r, step_s;
  logic [CW-1:0]      wait_cnt_r;
  logic               done_prev_r;
  logic               start_ok_s, done_edge_s, timeout_hit_s;
  logic [11:0]        in_s;
  logic signed [18:0] res_r [0:6];

  logic signed [18:0] px_s, qx_s, tx_s, py_s, qy_s, ty_s, pz_s, qz_s, tz_s;
  logic signed [18:0] a_s, b_s, c_s, d_s, e_s, f_s, g_s;
  logic               err_s;

  logic               ev_rst_r, ev_en_r, busy_r, valid_r, err_r, timeout_r;
  logic [3:0]         ev_in0_r, ev_in1_r, ev_in2_r;
  logic signed [4:0]  a_r, b_r, c_r, d_r, e_r, f_r, g_r;

  assign start_ok_s    = start && ((state_r == IDLE) || (state_r == DONE));
  // Only a fresh 0->1 transition counts, so a level left over from an earlier
  // step or run is never mistaken for a new result.
  assign done_edge_s   = (state_r == WAIT) && ev_done && !done_prev_r;
  assign timeout_hit_s = (state_r == WAIT) && !done_edge_s && (wait_cnt_r == WAIT_LAST);
  assign in_s          = step_inputs(step_s);

  // Next-state logic of the run sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) state_s = LAUNCH;
        else       state_s = state_r;
      end
      LAUNCH:  state_s = WAIT;
      WAIT: begin
        if (done_edge_s)        state_s = CAPTURE;
        else if (timeout_hit_s) state_s = DONE;
        else                    state_s = WAIT;
      end
      CAPTURE: begin
        if (step_r == LAST_STEP) state_s = COMPUTE;
        else                     state_s = LAUNCH;
      end
      COMPUTE: state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // Step index for the upcoming cycle: restart at S0, advance after each capture.
  always_comb begin
    step_s = step_r;
    if (start_ok_s) begin
      step_s = 3'd0;
    end else if ((state_r == CAPTURE) && (step_r != LAST_STEP)) begin
      step_s = step_r + 3'd1;
    end else begin
      step_s = step_r;
    end
  end

  // Coefficient recovery: with P = 4a+2b, Q = a+b the even term P-2Q equals 2a.
  always_comb begin
    px_s  = res_r[1] - res_r[0];
    qx_s  = res_r[2] - res_r[0];
    tx_s  = px_s - (qx_s <<< 1);
    a_s   = tx_s >>> 1;
    b_s   = qx_s - a_s;
    py_s  = res_r[3] - res_r[0];
    qy_s  = res_r[4] - res_r[0];
    ty_s  = py_s - (qy_s <<< 1);
    c_s   = ty_s >>> 1;
    d_s   = qy_s - c_s;
    pz_s  = res_r[5] - res_r[0];
    qz_s  = res_r[6] - res_r[0];
    tz_s  = pz_s - (qz_s <<< 1);
    e_s   = tz_s >>> 1;
    f_s   = qz_s - e_s;
    g_s   = res_r[0];
    err_s = tx_s[0] | ty_s[0] | tz_s[0] |
            !in_range(a_s) | !in_range(b_s) | !in_range(c_s) | !in_range(d_s) |
            !in_range(e_s) | !in_range(f_s) | !in_range(g_s);
  end

  // Sequencer state, step index, wait counter and ev_done history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      step_r      <= 3'd0;
      wait_cnt_r  <= CNT_ZERO;
      done_prev_r <= 1'b0;
    end else begin
      state_r <= state_s;
      step_r  <= step_s;
      if (state_r == WAIT) wait_cnt_r <= wait_cnt_r + CNT_ONE;
      else                 wait_cnt_r <= CNT_ZERO;
      // Zero during LAUNCH; afterwards follows ev_done so a held level blocks acceptance.
      if (state_s == LAUNCH) done_prev_r <= 1'b0;
      else                   done_prev_r <= ev_done;
    end
  end

  // Per-step result capture; reset discards any partial run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 7; i++) res_r[i] <= 19'sd0;
    end else if (state_r == CAPTURE) begin
      res_r[step_r] <= ev_out;
    end else begin
      res_r[step_r] <= res_r[step_r];
    end
  end

  // Evaluator-facing outputs and busy, registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ev_rst_r <= 1'b0;
      ev_en_r  <= 1'b0;
      busy_r   <= 1'b0;
      ev_in0_r <= 4'd0;
      ev_in1_r <= 4'd0;
      ev_in2_r <= 4'd0;
    end else begin
      ev_rst_r <= (state_s != LAUNCH);
      ev_en_r  <= (state_s == LAUNCH) || (state_s == WAIT);
      busy_r   <= (state_s == LAUNCH) || (state_s == WAIT) ||
                  (state_s == CAPTURE) || (state_s == COMPUTE);
      if ((state_s == LAUNCH) || (state_s == WAIT) || (state_s == CAPTURE)) begin
        {ev_in0_r, ev_in1_r, ev_in2_r} <= in_s;
      end else begin
        {ev_in0_r, ev_in1_r, ev_in2_r} <= 12'h000;
      end
    end
  end

  // Status flags and coefficient outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
      timeout_r <= 1'b0;
      a_r <= 5'sd0; b_r <= 5'sd0; c_r <= 5'sd0; d_r <= 5'sd0;
      e_r <= 5'sd0; f_r <= 5'sd0; g_r <= 5'sd0;
    end else if (start_ok_s) begin
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
      timeout_r <= 1'b0;
    end else if (timeout_hit_s) begin
      // Abort leaves the previous coefficients in place.
      valid_r   <= 1'b0;
      err_r     <= 1'b1;
      timeout_r <= 1'b1;
    end else if (state_r == COMPUTE) begin
      valid_r <= 1'b1;
      err_r   <= err_s;
      a_r <= a_s[4:0]; b_r <= b_s[4:0]; c_r <= c_s[4:0]; d_r <= d_s[4:0];
      e_r <= e_s[4:0]; f_r <= f_s[4:0]; g_r <= g_s[4:0];
    end else begin
      valid_r   <= valid_r;
      err_r     <= err_r;
      timeout_r <= timeout_r;
    end
  end

  assign ev_rst  = ev_rst_r;
  assign ev_en   = ev_en_r;
  assign ev_in0  = ev_in0_r;
  assign ev_in1  = ev_in1_r;
  assign ev_in2  = ev_in2_r;
  assign busy    = busy_r;
  assign valid   = valid_r;
  assign err     = err_r;
  assign timeout = timeout_r;
  assign a = a_r;
  assign b = b_r;
  assign c = c_r;
  assign d = d_r;
  assign e = e_r;
  assign f = f_r;
  assign g = g_r;

endmodule

// File: doc/poly_coef_extractor.md
POLY_COEF_EXTRACTOR -- requirements
Module: poly_coef_extractor

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max clk cycles waited per evaluation for ev_done before abort.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin an extraction run.
REQ-005 SHALL have port ev_rst  output  1  active-low restart driven to the downstream evaluator.
REQ-006 SHALL have port ev_en  output  1  evaluator enable.
REQ-007 SHALL have ports ev_in0, ev_in1, ev_in2  output  4 each  unsigned x, y, z to evaluator.
REQ-008 SHALL have port ev_out  input  19  signed F(x,y,z) from evaluator.
REQ-009 SHALL have port ev_done  input  1  evaluator result-ready flag.
REQ-010 SHALL have ports a, b, c, d, e, f, g  output  5 each  signed recovered coefficients of F = a x^2 + b x + c y^2 + d y + e z^2 + f z + g.
REQ-011 SHALL have ports busy, valid, err, timeout  output  1 each  status flags.

Function
REQ-012 SHALL run 7 evaluations in fixed order: S0 (0,0,0), S1 (2,0,0), S2 (1,0,0), S3 (0,2,0), S4 (0,1,0), S5 (0,0,2), S6 (0,0,1).
REQ-013 SHALL use FSM states IDLE, LAUNCH, WAIT, CAPTURE, COMPUTE, DONE; IDLE/DONE -> LAUNCH on start; LAUNCH -> WAIT after 1 cycle; WAIT -> CAPTURE on ev_done rising edge; CAPTURE -> LAUNCH (next step) or COMPUTE after S6; COMPUTE -> DONE after 1 cycle.
REQ-014 SHALL drive ev_rst=0 for exactly one cycle in LAUNCH, ev_rst=1 in all other states; ev_en=1 in LAUNCH and WAIT, else 0.
REQ-015 SHALL present step inputs on ev_in0..2 from LAUNCH cycle and hold them stable through WAIT and CAPTURE; 0 otherwise.
REQ-016 SHALL detect ev_done by rising edge (registered previous value, cleared in LAUNCH) so a level held from the prior run is never accepted.
REQ-017 SHALL capture ev_out into a 19-bit signed register per step in CAPTURE.
REQ-018 SHALL compute in 19-bit signed arithmetic: g=R0; P=R1-R0, Q=R2-R0; a=(P-2Q)>>>1; b=Q-a; same for c,d from R3,R4 and e,f from R5,R6.
REQ-019 SHALL set err if any (P-2Q) term is odd or any result lies outside [-16,15]; outputs then carry the low 5 bits.
REQ-020 SHALL count WAIT cycles; on reaching TIMEOUT without ev_done SHALL go to DONE with timeout=1, err=1, valid=0, coefficients unchanged.
REQ-021 SHALL assert busy in LAUNCH, WAIT, CAPTURE, COMPUTE; start while busy SHALL be ignored.
REQ-022 SHALL assert valid in DONE after a non-timeout run (including err runs) and hold a..g, valid, err until next accepted start, which clears valid, err, timeout in its first LAUNCH cycle.
REQ-023 SHALL complete a run in 7*(2+W)+2 cycles from start acceptance, W = per-step WAIT cycles including the ev_done edge cycle.

Reset
REQ-024 SHALL on rst=0 immediately (asynchronously) enter IDLE and force a..g=0, busy=0, valid=0, err=0, timeout=0, ev_en=0, ev_in0..2=0, ev_rst=0 while rst=0, then ev_rst=1 in IDLE.
REQ-025 SHALL on rst mid-run abandon all captured results; next run starts again at S0.

Verification
REQ-026 Evaluator model with a=5,b=8,c=-4,d=3,e=6,f=-2,g=13 (R0=13,R1=49,R2=26): start -> valid=1, err=0, outputs 5,8,-4,3,6,-2,13.
REQ-027 Extremes a=-16,b=15,c=15,d=-16,e=0,f=0,g=-16 -> exact values, err=0, no 19-bit overflow.
REQ-028 Model returns R1 corrupted by +1 (odd P-2Q) -> valid=1, err=1.
REQ-029 Model never raises ev_done at S3, TIMEOUT=20 -> timeout=1, err=1, valid=0 exactly 20 WAIT cycles after S3 LAUNCH.
REQ-030 Model holds ev_done high continuously between steps -> each step still waits for a fresh rising edge; result correct.
REQ-031 rst pulsed low during S4 WAIT, then start -> outputs 0 during reset; new run repeats S0..S6 and yields correct coefficients; start during busy has no effect.
